// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, synchronizes and debounces rows,
// reports the lowest pressed key code once per accepted press.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    logic [3:0]    row_meta, row_sync;
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx, col_idx_nxt;
    logic          acc_vld;
    logic [3:0]    acc_code;
    logic          prev_vld;
    logic [3:0]    prev_code;
    logic [SW-1:0] stable, stable_nxt;

    logic       dwell_last, scan_end, hit, scan_vld, same, reach;
    logic [1:0] hit_row;
    logic [3:0] scan_code;

    always_comb begin
        dwell_last = en && (dwell == DWELL_LAST);
        scan_end   = dwell_last && (col_idx == 2'd3);
        hit        = (row_sync != 4'hF);
        hit_row    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_sync[i]) hit_row = 2'(i);
        end
        // An earlier hit in this scan always wins over the column being sampled now.
        scan_vld   = acc_vld || (dwell_last && hit);
        scan_code  = acc_vld ? acc_code : {col_idx, hit_row};
        same       = (scan_vld == prev_vld) && (!scan_vld || (scan_code == prev_code));
        if (!same)
            stable_nxt = SW'(1);
        else if (stable == STABLE_MAX)
            stable_nxt = STABLE_MAX;
        else
            stable_nxt = stable + SW'(1);
        // Accept only on the scan that first reaches the threshold, not while saturated.
        reach       = (stable_nxt == STABLE_MAX) && !(same && (stable == STABLE_MAX));
        col_idx_nxt = !en ? 2'd0 : (dwell_last ? col_idx + 2'd1 : col_idx);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta  <= 4'hF;
            row_sync  <= 4'hF;
            dwell     <= '0;
            col_idx   <= 2'd0;
            col       <= 4'b1110;
            acc_vld   <= 1'b0;
            acc_code  <= 4'd0;
            prev_vld  <= 1'b0;
            prev_code <= 4'd0;
            stable    <= '0;
            key       <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            row_meta  <= row;
            row_sync  <= row_meta;
            col_idx   <= col_idx_nxt;
            col       <= en ? ~(4'b0001 << col_idx_nxt) : 4'hF;
            key_valid <= 1'b0;
            if (!en) begin
                dwell   <= '0;
                acc_vld <= 1'b0;
            end else begin
                dwell <= dwell_last ? '0 : dwell + DW'(1);
                if (scan_end) begin
                    acc_vld   <= 1'b0;
                    prev_vld  <= scan_vld;
                    prev_code <= scan_code;
                    stable    <= stable_nxt;
                    if (reach) begin
                        if (scan_vld) begin
                            if (!key_held || (scan_code != key)) begin
                                key       <= scan_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end
                        end else begin
                            key_held <= 1'b0;
                        end
                    end
                end else if (dwell_last && hit && !acc_vld) begin
                    acc_vld  <= 1'b1;
                    acc_code <= {col_idx, hit_row};
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: scan-aligned key masks, scan-level reference model, pulse scoreboard.
module tb_keypad_scanner;

    localparam int SD = 8;
    localparam int DB = 3;
    localparam int SCAN = 4 * SD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed = 16'h0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int exp_code_q[$];
    int exp_cyc_q[$];

    // Reference model state: run length of identical scan results and accepted key.
    int m_last = -1;
    int m_run  = 0;
    int m_key  = 0;
    int m_held = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk(clk), .rst(rst), .en(en), .row(row), .col(col),
        .key(key), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive keypad: a pressed switch pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col[c] && pressed[c*4+r]) row[r] = 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst && key_valid) begin
            if (exp_code_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got key %0d at cycle %0d, none expected", key, cyc);
            end else begin
                chk("pulse_key", int'(key), exp_code_q.pop_front());
                chk("pulse_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
    end

    task automatic model_reset();
        m_last = -1;
        m_run  = 0;
        m_key  = 0;
        m_held = 0;
    endtask

    // One full scan with a constant key mask, starting at a column-0 boundary.
    task automatic run_scan(input logic [15:0] mask);
        int cand;
        cand = -1;
        for (int b = 15; b >= 0; b--)
            if (mask[b]) cand = b;
        if (cand == m_last) m_run++;
        else begin
            m_last = cand;
            m_run  = 1;
        end
        if (m_run == DB) begin
            if (cand >= 0 && (m_held == 0 || cand != m_key)) begin
                m_key  = cand;
                m_held = 1;
                exp_code_q.push_back(cand);
                exp_cyc_q.push_back(cyc + SCAN);
            end else if (cand < 0) begin
                m_held = 0;
            end
        end
        pressed = mask;
        for (int i = 1; i <= SCAN; i++) begin
            @(negedge clk);
            if (i == 1) chk("col_first", int'(col), 4'b1110);
            if (i == SD + 1) chk("col_second", int'(col), 4'b1101);
        end
        chk("key_end_scan", int'(key), m_key);
        chk("held_end_scan", int'(key_held), m_held);
    endtask

    task automatic hold(input logic [15:0] mask, input int n);
        for (int s = 0; s < n; s++) run_scan(mask);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m;
        int dur;

        repeat (3) @(negedge clk);
        chk("rst_col", int'(col), 4'b1110);
        chk("rst_key", int'(key), 0);
        chk("rst_valid", int'(key_valid), 0);
        chk("rst_held", int'(key_held), 0);
        rst = 1'b1;

        // Single press of key 0x6, then release.
        hold(16'h0000, 2);
        hold(16'h0040, 5);
        hold(16'h0000, 4);

        // Bounce shorter than the debounce window, then settle.
        hold(16'h0040, 1);
        hold(16'h0000, 2);
        hold(16'h0040, 2);
        hold(16'h0000, 1);
        hold(16'h0040, 4);
        hold(16'h0000, 4);

        // Two keys together: lowest code 0x7 wins over 0x8.
        hold(16'h0180, 4);
        hold(16'h0000, 4);

        // Rollover 0x5 -> 0xA without release.
        hold(16'h0020, 4);
        hold(16'h0400, 4);

        // Enable drop mid-scan while 0xA is held.
        pressed = 16'h0400;
        repeat (13) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("en_off_col", int'(col), 4'b1111);
        repeat (20) @(negedge clk);
        chk("en_off_key", int'(key), m_key);
        chk("en_off_held", int'(key_held), m_held);
        en = 1'b1;
        hold(16'h0400, 4);
        hold(16'h0000, 4);

        // Randomized mask sequences.
        for (int t = 0; t < 50; t++) begin
            case ($urandom_range(0, 3))
                0: m = 16'h0000;
                1, 2: m = 16'h1 << $urandom_range(0, 15);
                default: m = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            endcase
            dur = $urandom_range(1, 5);
            hold(m, dur);
        end

        // Accept a key, then reset mid-scan.
        hold(16'h2000, 4);
        pressed = 16'h2000;
        repeat (13) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_col", int'(col), 4'b1110);
        chk("midrst_key", int'(key), 0);
        chk("midrst_valid", int'(key_valid), 0);
        chk("midrst_held", int'(key_held), 0);
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        hold(16'h2000, 4);
        hold(16'h0000, 4);

        repeat (4) @(negedge clk);
        chk("pending_pulses", exp_code_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
